// File: rtl/ysyx_24100005_ifu_pkg.sv
// Shared types and defaults for the instruction fetch unit.
`default_nettype none

package ysyx_24100005_ifu_pkg;

    localparam int          IFU_XLEN     = 32;
    localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/ysyx_24100005_pc_gen.sv
// Next-PC select: reset, then redirect, then sequential advance, else hold.
`default_nettype none

module ysyx_24100005_pc_gen
    import ysyx_24100005_ifu_pkg::*;
#(
    parameter int              XLEN     = IFU_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = IFU_RESET_PC
) (
    input  logic            rst_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            advance_i,
    input  logic [XLEN-1:0] pc_q_i,
    output logic [XLEN-1:0] pc_d_o
);

    always_comb begin
        pc_d_o = pc_q_i;
        if (rst_i) begin
            pc_d_o = RESET_PC;
        end else if (redirect_valid_i) begin
            pc_d_o = redirect_pc_i;
        end else if (advance_i) begin
            pc_d_o = pc_q_i + XLEN'(4);
        end
    end

endmodule

`default_nettype wire

// File: rtl/ysyx_24100005_ifu.sv
// Instruction fetch unit: owns the PC, issues one imem read at a time and
// hands the fetched word downstream over valid/ready, honouring redirects.
`default_nettype none

module ysyx_24100005_ifu
    import ysyx_24100005_ifu_pkg::*;
#(
    parameter int              XLEN     = IFU_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = IFU_RESET_PC
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    input  logic            imem_resp_err,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    output logic            inst_fault,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
);

    state_e          state_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic            drop_q;
    logic            inst_valid_q;
    logic [XLEN-1:0] inst_q;
    logic [XLEN-1:0] inst_pc_q;
    logic            inst_fault_q;

    logic            misaligned;
    logic            req_fire;
    logic            advance;

    assign misaligned     = |pc_q[1:0];
    assign imem_req_valid = !rst && (state_q == S_REQ) && !misaligned;
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign advance        = (state_q == S_HOLD) && inst_ready;

    ysyx_24100005_pc_gen #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc_gen (
        .rst_i            (rst),
        .redirect_valid_i (redirect_valid),
        .redirect_pc_i    (redirect_pc),
        .advance_i        (advance),
        .pc_q_i           (pc_q),
        .pc_d_o           (pc_d)
    );

    always_ff @(posedge clk) begin
        pc_q <= pc_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_REQ;
            drop_q       <= 1'b0;
            inst_valid_q <= 1'b0;
            inst_q       <= '0;
            inst_pc_q    <= RESET_PC;
            inst_fault_q <= 1'b0;
        end else begin
            case (state_q)
                S_REQ: begin
                    // A request already accepted under a redirect is stale; its response must be eaten.
                    if (redirect_valid) begin
                        if (req_fire) begin
                            state_q <= S_WAIT;
                            drop_q  <= 1'b1;
                        end
                    end else if (misaligned) begin
                        state_q      <= S_HOLD;
                        inst_valid_q <= 1'b1;
                        inst_fault_q <= 1'b1;
                        inst_q       <= '0;
                        inst_pc_q    <= pc_q;
                    end else if (req_fire) begin
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_resp_valid) begin
                        if (drop_q || redirect_valid) begin
                            drop_q  <= 1'b0;
                            state_q <= S_REQ;
                        end else begin
                            state_q      <= S_HOLD;
                            inst_valid_q <= 1'b1;
                            inst_q       <= imem_resp_err ? '0 : imem_resp_data;
                            inst_pc_q    <= pc_q;
                            inst_fault_q <= imem_resp_err;
                        end
                    end else if (redirect_valid) begin
                        drop_q <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (redirect_valid || inst_ready) begin
                        inst_valid_q <= 1'b0;
                        state_q      <= S_REQ;
                    end
                end
                default: begin
                    state_q <= S_REQ;
                end
            endcase
        end
    end

    assign inst_valid = inst_valid_q;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;
    assign inst_fault = inst_fault_q;

    a_resp_only_in_wait: assert property (@(posedge clk) disable iff (rst)
        imem_resp_valid |-> (state_q == S_WAIT))
        else $error("ifu: imem response arrived outside WAIT");

endmodule

`default_nettype wire
